// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter family.
// Optional lock feature of the arbiter is selected with the ARB_LOCK_EN macro.
package arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Modulo-n increment: returns 0 once val reaches n-1, else val+1.
    function automatic logic [31:0] mod_inc(input logic [31:0] val, input logic [31:0] n);
        logic [31:0] res;
        if (val >= (n - 32'd1)) begin
            res = 32'd0;
        end else begin
            res = val + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority pick: returns the first set bit of vec
// scanning ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1. Built as a doubled-vector
// priority encoder with a window of N_REQ bits starting at ptr.
module rr_pick #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] vec,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  id
);

    logic [2*N_REQ-1:0] dbl_s;

    assign dbl_s = {vec, vec};

    // Scan the doubled vector inside the [ptr, ptr+N_REQ) window; first hit wins.
    always_comb begin
        logic hit;
        found = 1'b0;
        id    = {ID_W{1'b0}};
        hit   = 1'b0;
        for (int i = 0; i < 2 * N_REQ; i++) begin
            hit = dbl_s[i] && (i >= int'(ptr)) && (i < int'(ptr) + N_REQ) && !found;
            if (hit) begin
                found = 1'b1;
                id    = (i >= N_REQ) ? ID_W'(i - N_REQ) : ID_W'(i);
            end else begin
                id = id;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_hs.sv
// Round-robin arbiter with a registered grant held under a valid/ready
// handshake. Back-to-back grants on accept; the accepted requester is masked
// in its accept cycle so a single request is never granted twice.
// Optional: define ARB_LOCK_EN to add req_lock, letting a locked requester
// keep the grant across accepts without advancing the pointer.
module rr_arbiter_hs
    import arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
`ifdef ARB_LOCK_EN
    input  logic [N_REQ-1:0] req_lock,
`endif
    input  logic             gnt_ready,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id,
    output logic [N_REQ-1:0] gnt_onehot
);

    arb_state_e       state_r;
    logic [ID_W-1:0]  ptr_r;
    logic             gnt_valid_r;
    logic [ID_W-1:0]  gnt_id_r;
    logic [N_REQ-1:0] gnt_onehot_r;

    logic [ID_W-1:0]  ptr_adv_s;
    logic [N_REQ-1:0] pick_vec_s;
    logic [ID_W-1:0]  pick_ptr_s;
    logic             pick_found_s;
    logic [ID_W-1:0]  pick_id_s;
    logic [N_REQ-1:0] pick_onehot_s;
    logic             hold_s;

    // Candidate selection: raw requests when idle, masked requests with the
    // advanced pointer when the current grant is being accepted.
    always_comb begin
        ptr_adv_s = ID_W'(mod_inc(32'(gnt_id_r), 32'(N_REQ)));
        if (state_r == ARB_GRANT) begin
            pick_vec_s = req & ~gnt_onehot_r;
            pick_ptr_s = ptr_adv_s;
        end else begin
            pick_vec_s = req;
            pick_ptr_s = ptr_r;
        end
    end

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .vec   (pick_vec_s),
        .ptr   (pick_ptr_s),
        .found (pick_found_s),
        .id    (pick_id_s)
    );

    // One-hot decode of the winner for the registered one-hot output.
    always_comb begin
        pick_onehot_s = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            pick_onehot_s[i] = (pick_id_s == ID_W'(i));
        end
    end

`ifdef ARB_LOCK_EN
    assign hold_s = req_lock[gnt_id_r] & req[gnt_id_r];
`else
    assign hold_s = 1'b0;
`endif

    // Arbitration FSM: registers state, pointer and all grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ARB_IDLE;
            ptr_r        <= {ID_W{1'b0}};
            gnt_valid_r  <= 1'b0;
            gnt_id_r     <= {ID_W{1'b0}};
            gnt_onehot_r <= {N_REQ{1'b0}};
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (|req) begin
                        state_r      <= ARB_GRANT;
                        gnt_valid_r  <= 1'b1;
                        gnt_id_r     <= pick_id_s;
                        gnt_onehot_r <= pick_onehot_s;
                    end else begin
                        gnt_valid_r  <= 1'b0;
                        gnt_onehot_r <= {N_REQ{1'b0}};
                    end
                end
                ARB_GRANT: begin
                    if (!gnt_ready) begin
                        // Committed grant: hold everything until accepted.
                        state_r <= ARB_GRANT;
                    end else if (hold_s) begin
                        // Locked requester keeps the grant; pointer stays.
                        state_r <= ARB_GRANT;
                    end else begin
                        ptr_r <= ptr_adv_s;
                        if (pick_found_s) begin
                            state_r      <= ARB_GRANT;
                            gnt_valid_r  <= 1'b1;
                            gnt_id_r     <= pick_id_s;
                            gnt_onehot_r <= pick_onehot_s;
                        end else begin
                            state_r      <= ARB_IDLE;
                            gnt_valid_r  <= 1'b0;
                            gnt_onehot_r <= {N_REQ{1'b0}};
                        end
                    end
                end
                default: begin
                    state_r      <= ARB_IDLE;
                    ptr_r        <= {ID_W{1'b0}};
                    gnt_valid_r  <= 1'b0;
                    gnt_id_r     <= {ID_W{1'b0}};
                    gnt_onehot_r <= {N_REQ{1'b0}};
                end
            endcase
        end
    end

    assign gnt_valid  = gnt_valid_r;
    assign gnt_id     = gnt_id_r;
    assign gnt_onehot = gnt_onehot_r;

endmodule

// File: tb/tb_rr_arbiter_hs.sv
// Scoreboard bench for rr_arbiter_hs: a 4-requester and a 5-requester instance.
// Stimulus pushes expected grant ids; per-instance monitors compare on the
// falling edge whenever a grant is presented and pop on accept.
module tb_rr_arbiter_hs;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       gnt_ready;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic [3:0] gnt_onehot;

    logic [4:0] req5;
    logic       gnt_ready5;
    logic       gnt_valid5;
    logic [2:0] gnt_id5;
    logic [4:0] gnt_onehot5;

`ifdef ARB_LOCK_EN
    logic [3:0] req_lock;
    logic [4:0] req_lock5;
`endif

    int n_cmp;
    int n_err;
    int sb4[$];
    int sb5[$];

    rr_arbiter_hs #(.N_REQ(4)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
`ifdef ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .gnt_ready  (gnt_ready),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id),
        .gnt_onehot (gnt_onehot)
    );

    rr_arbiter_hs #(.N_REQ(5)) u_dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req5),
`ifdef ARB_LOCK_EN
        .req_lock   (req_lock5),
`endif
        .gnt_ready  (gnt_ready5),
        .gnt_valid  (gnt_valid5),
        .gnt_id     (gnt_id5),
        .gnt_onehot (gnt_onehot5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 4'd0; gnt_ready = 1'b0;
        req5 = 5'd0; gnt_ready5 = 1'b0;
`ifdef ARB_LOCK_EN
        req_lock = 4'd0; req_lock5 = 5'd0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
    endtask

    // Monitor for the 4-requester instance.
    always @(negedge clk) begin
        logic [3:0] one4;
        int e;
        one4 = 4'b0001;
        if (rst_n) begin
            if (gnt_valid) begin
                n_cmp++;
                if (sb4.size() == 0) begin
                    n_err++;
                    $display("FAIL grant4_unexpected: got id %0d expected no grant at %0t", gnt_id, $time);
                end else begin
                    e = sb4[0];
                    if (gnt_id !== 2'(e) || gnt_onehot !== (one4 << e)) begin
                        n_err++;
                        $display("FAIL grant4: got id %0d onehot %b expected id %0d at %0t",
                                 gnt_id, gnt_onehot, e, $time);
                    end
                    if (gnt_ready) void'(sb4.pop_front());
                end
            end else begin
                n_cmp++;
                if (gnt_onehot !== 4'd0) begin
                    n_err++;
                    $display("FAIL onehot4_idle: got %b expected 0000 at %0t", gnt_onehot, $time);
                end
            end
        end
    end

    // Monitor for the 5-requester instance.
    always @(negedge clk) begin
        logic [4:0] one5;
        int e;
        one5 = 5'b00001;
        if (rst_n && gnt_valid5) begin
            n_cmp++;
            if (sb5.size() == 0) begin
                n_err++;
                $display("FAIL grant5_unexpected: got id %0d expected no grant at %0t", gnt_id5, $time);
            end else begin
                e = sb5[0];
                if (gnt_id5 !== 3'(e) || gnt_onehot5 !== (one5 << e)) begin
                    n_err++;
                    $display("FAIL grant5: got id %0d onehot %b expected id %0d at %0t",
                             gnt_id5, gnt_onehot5, e, $time);
                end
                if (gnt_ready5) void'(sb5.pop_front());
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        do_reset();

        // Idle with no requests: nothing granted, id stays 0.
        for (int i = 0; i < 5; i++) begin
            chk("idle_valid", 32'(gnt_valid), 32'd0);
            chk("idle_id", 32'(gnt_id), 32'd0);
            cyc(1);
        end

`ifdef ARB_LOCK_EN
        // Lock: requester 0 keeps the grant for three accepts, then rotates.
        sb4.push_back(0); sb4.push_back(0); sb4.push_back(0);
        sb4.push_back(0); sb4.push_back(1);
        req = 4'b0011; req_lock = 4'b0001; gnt_ready = 1'b1;
        cyc(4);
        req_lock = 4'b0000;
        cyc(1);
        req = 4'b0000;
        cyc(1);
        chk("lock_end_idle", 32'(gnt_valid), 32'd0);
        do_reset();
`endif

        // Full load, always ready: back-to-back 0,1,2,3,0.
        sb4.push_back(0); sb4.push_back(1); sb4.push_back(2);
        sb4.push_back(3); sb4.push_back(0);
        req = 4'b1111; gnt_ready = 1'b1;
        cyc(5);
        req = 4'b0000;
        cyc(1);
        chk("rotate_end_idle", 32'(gnt_valid), 32'd0);
        gnt_ready = 1'b0;
        do_reset();

        // Grant held while not ready, even after req drops.
        sb4.push_back(2);
        req = 4'b0100; gnt_ready = 1'b0;
        cyc(1);
        chk("latency_valid", 32'(gnt_valid), 32'd1);
        cyc(1);
        req = 4'b0000;
        cyc(1);
        chk("held_valid", 32'(gnt_valid), 32'd1);
        chk("held_id", 32'(gnt_id), 32'd2);
        gnt_ready = 1'b1;
        cyc(1);
        chk("held_accept_idle", 32'(gnt_valid), 32'd0);
        gnt_ready = 1'b0;
        do_reset();

        // Reset in the middle of a grant to requester 3.
        sb4.push_back(3);
        req = 4'b1000; gnt_ready = 1'b0;
        cyc(1);
        chk("pre_rst_id", 32'(gnt_id), 32'd3);
        #2;
        rst_n = 1'b0;
        sb4.delete();
        #1;
        chk("async_rst_valid", 32'(gnt_valid), 32'd0);
        chk("async_rst_id", 32'(gnt_id), 32'd0);
        chk("async_rst_onehot", 32'(gnt_onehot), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        // Pointer back at 0: with 0 and 3 requesting, 0 wins first.
        sb4.push_back(0); sb4.push_back(3);
        req = 4'b1001; gnt_ready = 1'b1;
        cyc(2);
        req = 4'b0000;
        cyc(1);
        sb4.push_back(3);
        req = 4'b1000;
        cyc(1);
        req = 4'b0000;
        cyc(1);
        gnt_ready = 1'b0;
        chk("post_rst_idle", 32'(gnt_valid), 32'd0);

        // Five requesters: move ptr to 4, then wrap 4 -> 0, then ptr=1.
        sb5.push_back(3);
        req5 = 5'b01000; gnt_ready5 = 1'b1;
        cyc(1);
        sb5.push_back(4); sb5.push_back(0);
        req5 = 5'b10001;
        cyc(2);
        req5 = 5'b00000;
        cyc(1);
        chk("wrap5_idle", 32'(gnt_valid5), 32'd0);
        sb5.push_back(1); sb5.push_back(0);
        req5 = 5'b00011;
        cyc(2);
        req5 = 5'b00000;
        cyc(1);
        chk("ptr5_end_idle", 32'(gnt_valid5), 32'd0);
        gnt_ready5 = 1'b0;
        cyc(2);

        chk("sb4_drained", 32'(sb4.size()), 32'd0);
        chk("sb5_drained", 32'(sb5.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
